// File: rtl/ddram_rom_pkg.sv
// Shared types and constants for the DDR3 ROM responder port.
package ddram_rom_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RDWAIT
    } state_t;

    localparam int unsigned DDR_WORD_W   = 64;
    localparam logic [7:0]  BURST_ONE    = 8'd1;
    localparam logic [28:0] DEFAULT_BASE = 29'h0600_0000;

endpackage

// File: rtl/ddram_rom_port.sv
// Toggle req/ack ROM port onto DDR3 Avalon-MM: 16-bit ROM-load writes, 64-bit fetches
// with a single-word read cache. One outstanding DDR3 transaction at a time.
module ddram_rom_port
    import ddram_rom_pkg::*;
#(
    parameter int unsigned ADDR_W = 25,
    parameter logic [28:0] BASE   = DEFAULT_BASE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     wraddr,
    input  logic [15:0]           din,
    input  logic                  we_req,
    output logic                  we_ack,
    input  logic [ADDR_W-1:0]     rdaddr,
    output logic [DDR_WORD_W-1:0] dout,
    input  logic                  rd_req,
    output logic                  rd_ack,
    input  logic                  DDRAM_BUSY,
    output logic [7:0]            DDRAM_BURSTCNT,
    output logic [28:0]           DDRAM_ADDR,
    input  logic [DDR_WORD_W-1:0] DDRAM_DOUT,
    input  logic                  DDRAM_DOUT_READY,
    output logic                  DDRAM_RD,
    output logic [DDR_WORD_W-1:0] DDRAM_DIN,
    output logic [7:0]            DDRAM_BE,
    output logic                  DDRAM_WE
);

    localparam int unsigned TAG_W = ADDR_W - 3;

    state_t                  state_q;
    logic                    we_ack_q, rd_ack_q;
    logic                    we_tgl_q, rd_tgl_q;
    logic [DDR_WORD_W-1:0]   dout_q, cache_q, din_q;
    logic [TAG_W-1:0]        tag_q, wr_tag_q, rd_tag_q;
    logic                    cache_valid_q, drain_q;
    logic                    rd_q, we_q;
    logic [28:0]             addr_q;
    logic [7:0]              be_q;

    logic [TAG_W-1:0]        wr_word, rd_word;
    logic                    wr_pend, rd_pend, hit;
    logic                    unused_addr_bits;

    assign wr_word = wraddr[ADDR_W-1:3];
    assign rd_word = rdaddr[ADDR_W-1:3];
    assign wr_pend = we_req != we_ack_q;
    assign rd_pend = rd_req != rd_ack_q;
    assign hit     = cache_valid_q && (tag_q == rd_word);
    assign unused_addr_bits = ^{wraddr[0], rdaddr[2:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            we_ack_q      <= 1'b0;
            rd_ack_q      <= 1'b0;
            we_tgl_q      <= 1'b0;
            rd_tgl_q      <= 1'b0;
            dout_q        <= '0;
            cache_q       <= '0;
            din_q         <= '0;
            tag_q         <= '0;
            wr_tag_q      <= '0;
            rd_tag_q      <= '0;
            cache_valid_q <= 1'b0;
            rd_q          <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= BASE;
            be_q          <= '0;
            // A read already accepted by DDR3 will still return a beat; swallow it later.
            drain_q       <= ((state_q == S_RD) && !DDRAM_BUSY)
                          || ((state_q == S_RDWAIT) && !DDRAM_DOUT_READY)
                          || (drain_q && !DDRAM_DOUT_READY);
        end else begin
            if (drain_q && DDRAM_DOUT_READY)
                drain_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (wr_pend) begin
                        we_tgl_q <= we_req;
                        wr_tag_q <= wr_word;
                        we_q     <= 1'b1;
                        addr_q   <= BASE + 29'(wr_word);
                        din_q    <= {4{din}};
                        be_q     <= 8'b0000_0011 << {wraddr[2:1], 1'b0};
                        state_q  <= S_WR;
                    end else if (rd_pend) begin
                        if (hit) begin
                            dout_q   <= cache_q;
                            rd_ack_q <= rd_req;
                        end else if (!drain_q) begin
                            rd_tgl_q <= rd_req;
                            rd_tag_q <= rd_word;
                            rd_q     <= 1'b1;
                            addr_q   <= BASE + 29'(rd_word);
                            state_q  <= S_RD;
                        end
                    end
                end
                S_WR: begin
                    if (!DDRAM_BUSY) begin
                        we_q     <= 1'b0;
                        we_ack_q <= we_tgl_q;
                        if (tag_q == wr_tag_q)
                            cache_valid_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                S_RD: begin
                    if (!DDRAM_BUSY) begin
                        rd_q    <= 1'b0;
                        state_q <= S_RDWAIT;
                    end
                end
                S_RDWAIT: begin
                    if (DDRAM_DOUT_READY) begin
                        dout_q        <= DDRAM_DOUT;
                        cache_q       <= DDRAM_DOUT;
                        tag_q         <= rd_tag_q;
                        cache_valid_q <= 1'b1;
                        rd_ack_q      <= rd_tgl_q;
                        state_q       <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign we_ack         = we_ack_q;
    assign rd_ack         = rd_ack_q;
    assign dout           = dout_q;
    assign DDRAM_BURSTCNT = BURST_ONE;
    assign DDRAM_ADDR     = addr_q;
    assign DDRAM_RD       = rd_q;
    assign DDRAM_WE       = we_q;
    assign DDRAM_DIN      = din_q;
    assign DDRAM_BE       = be_q;

endmodule

// File: tb/tb_ddram_rom_port.sv
// Directed bench for ddram_rom_port with a read-data scoreboard and an Avalon bus monitor.
module tb_ddram_rom_port;
    import ddram_rom_pkg::*;

    localparam logic [28:0] BASE = 29'h0600_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [24:0] wraddr, rdaddr;
    logic [15:0] din;
    logic        we_req, we_ack, rd_req, rd_ack;
    logic [63:0] dout;
    logic        DDRAM_BUSY, DDRAM_DOUT_READY, DDRAM_RD, DDRAM_WE;
    logic [7:0]  DDRAM_BURSTCNT, DDRAM_BE;
    logic [28:0] DDRAM_ADDR;
    logic [63:0] DDRAM_DOUT, DDRAM_DIN;

    ddram_rom_port #(.ADDR_W(25), .BASE(BASE)) dut (
        .clk(clk), .reset(reset),
        .wraddr(wraddr), .din(din), .we_req(we_req), .we_ack(we_ack),
        .rdaddr(rdaddr), .dout(dout), .rd_req(rd_req), .rd_ack(rd_ack),
        .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_ADDR(DDRAM_ADDR),
        .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY), .DDRAM_RD(DDRAM_RD),
        .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE), .DDRAM_WE(DDRAM_WE)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [63:0] exp_q[$];
    int rd_cmds = 0, wr_cmds = 0, we_tog = 0, rd_tog = 0;
    int wr_reqs = 0, rd_reqs = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bus monitor: command exclusivity, hold-while-busy, accepted commands, ack toggles.
    logic        prev_valid = 1'b0;
    logic        prev_rd, prev_we, prev_busy, prev_we_ack, prev_rd_ack;
    logic [28:0] prev_addr;
    always @(posedge clk) begin
        if (reset) begin
            rd_cmds = 0; wr_cmds = 0; we_tog = 0; rd_tog = 0;
        end else if (prev_valid) begin
            if (DDRAM_RD || DDRAM_WE)
                check("cmd_exclusive", {63'd0, DDRAM_RD & DDRAM_WE}, 64'd0);
            if ((prev_rd || prev_we) && prev_busy) begin
                check("cmd_hold", {62'd0, DDRAM_RD, DDRAM_WE}, {62'd0, prev_rd, prev_we});
                check("addr_hold", DDRAM_ADDR, prev_addr);
            end
            if (DDRAM_RD && !DDRAM_BUSY) rd_cmds++;
            if (DDRAM_WE && !DDRAM_BUSY) wr_cmds++;
            if (we_ack !== prev_we_ack) we_tog++;
            if (rd_ack !== prev_rd_ack) rd_tog++;
        end
        prev_valid  = !reset;
        prev_rd     = DDRAM_RD;
        prev_we     = DDRAM_WE;
        prev_busy   = DDRAM_BUSY;
        prev_addr   = DDRAM_ADDR;
        prev_we_ack = we_ack;
        prev_rd_ack = rd_ack;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_we(input int budget);
        int n = 0;
        while (we_ack !== we_req && n < budget) begin tick(); n++; end
        check("we_ack", {63'd0, we_ack}, {63'd0, we_req});
    endtask

    task automatic wait_rd(input int budget, output int lat);
        lat = 0;
        while (rd_ack !== rd_req && lat < budget) begin tick(); lat++; end
        check("rd_ack", {63'd0, rd_ack}, {63'd0, rd_req});
        check("sb_depth", exp_q.size(), 1);
        if (exp_q.size() != 0) check("dout", dout, exp_q.pop_front());
    endtask

    task automatic do_write(input logic [24:0] a, input logic [15:0] d,
                            input int busy_cycles, input logic [7:0] exp_be);
        logic [28:0] word;
        word = 29'(a >> 3);
        wraddr = a; din = d; we_req = ~we_req; wr_reqs++;
        DDRAM_BUSY = (busy_cycles > 0);
        tick();
        check("we_issue", {63'd0, DDRAM_WE}, 64'd1);
        check("wr_addr", {35'd0, DDRAM_ADDR}, {35'd0, BASE + word});
        check("wr_be", {56'd0, DDRAM_BE}, {56'd0, exp_be});
        check("wr_din", DDRAM_DIN, {d, d, d, d});
        check("we_ack_early", {63'd0, we_ack}, {63'd0, ~we_req});
        for (int i = 0; i < busy_cycles; i++) begin
            tick();
            check("we_held", {63'd0, DDRAM_WE}, 64'd1);
        end
        DDRAM_BUSY = 1'b0;
        tick();
        check("we_drop", {63'd0, DDRAM_WE}, 64'd0);
        wait_we(4);
    endtask

    task automatic do_read_miss(input logic [24:0] a, input logic [63:0] data,
                                input int busy_cycles, input int ready_delay);
        int n0, lat;
        logic [28:0] word;
        word = 29'(a >> 3);
        n0 = rd_cmds;
        rdaddr = a; rd_req = ~rd_req; rd_reqs++; exp_q.push_back(data);
        DDRAM_BUSY = (busy_cycles > 0);
        tick();
        check("rd_issue", {63'd0, DDRAM_RD}, 64'd1);
        check("rd_addr", {35'd0, DDRAM_ADDR}, {35'd0, BASE + word});
        for (int i = 0; i < busy_cycles; i++) begin
            tick();
            check("rd_held", {63'd0, DDRAM_RD}, 64'd1);
        end
        DDRAM_BUSY = 1'b0;
        tick();
        check("rd_drop", {63'd0, DDRAM_RD}, 64'd0);
        check("rd_cmds", rd_cmds, n0 + 1);
        repeat (ready_delay) tick();
        DDRAM_DOUT = data; DDRAM_DOUT_READY = 1'b1;
        tick();
        DDRAM_DOUT_READY = 1'b0; DDRAM_DOUT = '0;
        wait_rd(4, lat);
        check("miss_ack_lat", lat, 0);
    endtask

    task automatic do_read_hit(input logic [24:0] a, input logic [63:0] data);
        int n0, lat;
        n0 = rd_cmds;
        rdaddr = a; rd_req = ~rd_req; rd_reqs++; exp_q.push_back(data);
        wait_rd(4, lat);
        check("hit_lat", lat, 1);
        check("hit_no_rd", rd_cmds, n0);
    endtask

    initial begin
        int lat;
        reset = 1'b1; wraddr = '0; rdaddr = '0; din = '0; we_req = 1'b0; rd_req = 1'b0;
        DDRAM_BUSY = 1'b0; DDRAM_DOUT_READY = 1'b0; DDRAM_DOUT = '0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_we_ack", {63'd0, we_ack}, 64'd0);
        check("rst_rd_ack", {63'd0, rd_ack}, 64'd0);
        check("rst_dout", dout, 64'd0);
        check("rst_addr", {35'd0, DDRAM_ADDR}, {35'd0, BASE});
        check("rst_be", {56'd0, DDRAM_BE}, 64'd0);
        check("burstcnt", {56'd0, DDRAM_BURSTCNT}, 64'd1);

        // Idle with no requests: no bus activity.
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_cmds", {62'd0, DDRAM_RD, DDRAM_WE}, 64'd0);
        end
        check("idle_rd_cmds", rd_cmds, 0);
        check("idle_wr_cmds", wr_cmds, 0);
        check("idle_addr", {35'd0, DDRAM_ADDR}, {35'd0, BASE});

        // Single write, upper halfword lane.
        do_write(25'h000006, 16'hA55A, 0, 8'hC0);
        check("wr_cmds", wr_cmds, 1);

        // Miss with 3 busy cycles, then a repeat hit.
        do_read_miss(25'h000008, 64'h0123_4567_89AB_CDEF, 3, 4);
        do_read_hit(25'h00000F, 64'h0123_4567_89AB_CDEF);

        // Write to the cached word invalidates; write to another word does not.
        do_write(25'h000008, 16'h1234, 2, 8'h03);
        do_read_miss(25'h000008, 64'hFEDC_BA98_7654_3210, 0, 2);
        do_write(25'h000014, 16'h5678, 0, 8'h30);
        do_read_hit(25'h000008, 64'hFEDC_BA98_7654_3210);

        // Simultaneous write and read requests: write serviced first.
        wraddr = 25'h000010; din = 16'hBEEF; rdaddr = 25'h000018;
        we_req = ~we_req; rd_req = ~rd_req; wr_reqs++; rd_reqs++;
        exp_q.push_back(64'h1111_2222_3333_4444);
        DDRAM_BUSY = 1'b0;
        tick();
        check("sim_we_first", {62'd0, DDRAM_WE, DDRAM_RD}, 64'd2);
        check("sim_wr_addr", {35'd0, DDRAM_ADDR}, {35'd0, BASE + 29'd2});
        tick();
        check("sim_we_done", {63'd0, we_ack}, {63'd0, we_req});
        check("sim_rd_pending", {63'd0, rd_ack}, {63'd0, ~rd_req});
        tick();
        check("sim_rd_next", {62'd0, DDRAM_WE, DDRAM_RD}, 64'd1);
        check("sim_rd_addr", {35'd0, DDRAM_ADDR}, {35'd0, BASE + 29'd3});
        tick();
        tick();
        DDRAM_DOUT = 64'h1111_2222_3333_4444; DDRAM_DOUT_READY = 1'b1;
        tick();
        DDRAM_DOUT_READY = 1'b0; DDRAM_DOUT = '0;
        wait_rd(4, lat);
        tick();
        check("we_toggles", we_tog, wr_reqs);
        check("rd_toggles", rd_tog, rd_reqs);

        // Reset while a read is outstanding; the stale beat must be dropped.
        rdaddr = 25'h000020; rd_req = ~rd_req; rd_reqs++;
        DDRAM_BUSY = 1'b0;
        tick();
        check("drn_rd_issue", {63'd0, DDRAM_RD}, 64'd1);
        tick();
        reset = 1'b1; we_req = 1'b0; rd_req = 1'b0;
        exp_q.delete(); wr_reqs = 0; rd_reqs = 0;
        tick();
        reset = 1'b0;
        check("drn_rst_cmds", {62'd0, DDRAM_RD, DDRAM_WE}, 64'd0);
        check("drn_rst_ack", {63'd0, rd_ack}, 64'd0);
        check("drn_rst_dout", dout, 64'd0);
        check("drn_rst_addr", {35'd0, DDRAM_ADDR}, {35'd0, BASE});
        rdaddr = 25'h000028; rd_req = 1'b1; rd_reqs++;
        exp_q.push_back(64'hCAFE_F00D_DEAD_BEEF);
        tick();
        tick();
        check("drn_blocked", {63'd0, DDRAM_RD}, 64'd0);
        DDRAM_DOUT = 64'h5555_AAAA_5555_AAAA; DDRAM_DOUT_READY = 1'b1;
        tick();
        DDRAM_DOUT_READY = 1'b0; DDRAM_DOUT = '0;
        check("drn_stale_ack", {63'd0, rd_ack}, 64'd0);
        check("drn_stale_dout", dout, 64'd0);
        tick();
        check("drn_rd_issue2", {63'd0, DDRAM_RD}, 64'd1);
        check("drn_rd_addr2", {35'd0, DDRAM_ADDR}, {35'd0, BASE + 29'd5});
        tick();
        check("drn_rd_drop2", {63'd0, DDRAM_RD}, 64'd0);
        tick();
        DDRAM_DOUT = 64'hCAFE_F00D_DEAD_BEEF; DDRAM_DOUT_READY = 1'b1;
        tick();
        DDRAM_DOUT_READY = 1'b0; DDRAM_DOUT = '0;
        wait_rd(4, lat);
        tick();
        check("drn_rd_toggles", rd_tog, rd_reqs);
        check("drn_rd_cmds", rd_cmds, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
